// File: rtl/mem_bus_if.sv
// Data bus between the MEM stage and memory: req/ack handshake with byte enables.
interface mem_bus_if #(
    parameter int unsigned BUS_AW = 32
) ();
    logic              bus_req;
    logic              bus_we;
    logic [BUS_AW-1:0] bus_addr;
    logic [3:0]        bus_sel;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access.sv
// MIPS MEM stage: ALU pass-through, big-endian load/store over a req/ack bus, pipeline stall.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
    parameter int unsigned BUS_AW = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ex_wd,
    input  logic        i_ex_wreg,
    input  logic [31:0] i_ex_wdata,
    input  logic [3:0]  i_ex_mem_op,
    input  logic [31:0] i_ex_mem_addr,
    input  logic [31:0] i_ex_reg2,
    output logic [4:0]  o_mem_wd,
    output logic        o_mem_wreg,
    output logic [31:0] o_mem_wdata,
    output logic        o_stallreq,
    output logic        o_misalign,
    mem_bus_if.master   bus
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state, w_next;
    logic              r_bus_req, r_bus_we;
    logic [BUS_AW-1:0] r_bus_addr;
    logic [3:0]        r_bus_sel;
    logic [31:0]       r_bus_wdata;
    logic [31:0]       r_load_data;

    logic        w_is_load, w_is_store, w_is_mem, w_misalign, w_start;
    logic [3:0]  w_sel;
    logic [31:0] w_st_data, w_ld_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_is_load  = (i_ex_mem_op >= OP_LB) && (i_ex_mem_op <= OP_LW);
    assign w_is_store = (i_ex_mem_op >= OP_SB) && (i_ex_mem_op <= OP_SW);
    assign w_is_mem   = w_is_load || w_is_store;

    // Big-endian lane selection and store-data replication
    always_comb begin
        w_sel     = 4'b0000;
        w_st_data = 32'h0;
        case (i_ex_mem_op)
            OP_LB, OP_LBU, OP_SB: w_sel = 4'b1000 >> i_ex_mem_addr[1:0];
            OP_LH, OP_LHU, OP_SH: w_sel = i_ex_mem_addr[1] ? 4'b0011 : 4'b1100;
            OP_LW, OP_SW:         w_sel = 4'b1111;
            default:              w_sel = 4'b0000;
        endcase
        case (i_ex_mem_op)
            OP_SB:   w_st_data = {4{i_ex_reg2[7:0]}};
            OP_SH:   w_st_data = {2{i_ex_reg2[15:0]}};
            OP_SW:   w_st_data = i_ex_reg2;
            default: w_st_data = 32'h0;
        endcase
    end

    // Load lane extraction with sign/zero extension
    always_comb begin
        w_byte = 8'h0;
        case (i_ex_mem_addr[1:0])
            2'd0:    w_byte = bus.bus_rdata[31:24];
            2'd1:    w_byte = bus.bus_rdata[23:16];
            2'd2:    w_byte = bus.bus_rdata[15:8];
            default: w_byte = bus.bus_rdata[7:0];
        endcase
        w_half = i_ex_mem_addr[1] ? bus.bus_rdata[15:0] : bus.bus_rdata[31:16];
        case (i_ex_mem_op)
            OP_LB:   w_ld_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ld_ext = {24'h0, w_byte};
            OP_LH:   w_ld_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ld_ext = {16'h0, w_half};
            default: w_ld_ext = bus.bus_rdata;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        case (i_ex_mem_op)
            OP_LH, OP_LHU, OP_SH: w_misalign = i_ex_mem_addr[0];
            OP_LW, OP_SW:         w_misalign = |i_ex_mem_addr[1:0];
            default:              w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Next state and combinational pipeline outputs
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        o_stallreq  = 1'b0;
        o_misalign  = 1'b0;
        o_mem_wd    = i_ex_wd;
        o_mem_wreg  = i_ex_wreg && !w_is_store;
        o_mem_wdata = i_ex_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_misalign) begin
                    o_misalign = 1'b1;
                    o_mem_wreg = 1'b0;
                end else if (w_is_mem) begin
                    o_stallreq = 1'b1;
                    o_mem_wreg = 1'b0;
                    w_start    = 1'b1;
                    w_next     = S_BUSY;
                end
            end
            S_BUSY: begin
                o_stallreq = 1'b1;
                o_mem_wreg = 1'b0;
                if (bus.bus_ack) w_next = S_DONE;
            end
            S_DONE: begin
                if (w_is_load) o_mem_wdata = r_load_data;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            o_stallreq  = 1'b0;
            o_misalign  = 1'b0;
            o_mem_wd    = 5'd0;
            o_mem_wreg  = 1'b0;
            o_mem_wdata = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= 32'h0;
            r_load_data <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= w_is_store;
                r_bus_addr  <= {i_ex_mem_addr[BUS_AW-1:2], 2'b00};
                r_bus_sel   <= w_sel;
                r_bus_wdata <= w_st_data;
            end else if (r_state == S_BUSY && bus.bus_ack) begin
                r_bus_req   <= 1'b0;
                r_bus_we    <= 1'b0;
                r_load_data <= w_ld_ext;
            end
        end
    end

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_sel   = r_bus_sel;
    assign bus.bus_wdata = r_bus_wdata;
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: driver queues expectations, monitor/responder compare.
module tb_mem_access;
    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        mis;
        int          stall;
    } res_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_addr, ex_reg2;
    logic [3:0]  ex_op;
    logic [4:0]  mem_wd;
    logic        mem_wreg, stallreq, misalign;
    logic [31:0] mem_wdata;

    logic        resp_ack   = 1'b0;
    logic        man_ack    = 1'b0;
    logic [31:0] resp_rdata = 32'h0;
    logic [31:0] rd_val     = 32'h0;
    int          ack_delay  = 0;

    res_t res_q[$];
    bus_t bus_q[$];
    bit   live      = 1'b0;
    int   stall_cnt = 0;
    int   n_chk     = 0;
    int   n_pass    = 0;

    mem_bus_if #(.BUS_AW(32)) bus ();
    assign bus.bus_ack   = resp_ack | man_ack;
    assign bus.bus_rdata = resp_rdata;

    mem_access #(.BUS_AW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_ex_wd       (ex_wd),
        .i_ex_wreg     (ex_wreg),
        .i_ex_wdata    (ex_wdata),
        .i_ex_mem_op   (ex_op),
        .i_ex_mem_addr (ex_addr),
        .i_ex_reg2     (ex_reg2),
        .o_mem_wd      (mem_wd),
        .o_mem_wreg    (mem_wreg),
        .o_mem_wdata   (mem_wdata),
        .o_stallreq    (stallreq),
        .o_misalign    (misalign),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // Monitor: a result is presented whenever the stage is not stalling
    always @(negedge clk) begin
        if (!rst && live) begin
            if (stallreq) begin
                stall_cnt++;
            end else begin
                if (res_q.size() == 0) begin
                    chk("res_unexpected", 32'd1, 32'd0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("mem_wd",    32'(mem_wd),    32'(r.wd));
                    chk("mem_wreg",  32'(mem_wreg),  32'(r.wreg));
                    chk("mem_wdata", mem_wdata,      r.wdata);
                    chk("misalign",  32'(misalign),  32'(r.mis));
                    chk("stall_len", 32'(stall_cnt), 32'(r.stall));
                end
                stall_cnt = 0;
                live      = 1'b0;
            end
        end
    end

    // Bus responder: checks the request once, then acks after ack_delay cycles
    int  cnt  = 0;
    bit  seen = 1'b0;
    always @(negedge clk) begin
        if (resp_ack) begin
            resp_ack = 1'b0;
        end else if (!rst && bus.bus_req) begin
            if (!seen) begin
                seen = 1'b1;
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    chk("bus_we",    32'(bus.bus_we),  32'(b.we));
                    chk("bus_addr",  bus.bus_addr,     b.addr);
                    chk("bus_sel",   32'(bus.bus_sel), 32'(b.sel));
                    chk("bus_wdata", bus.bus_wdata,    b.wdata);
                end
            end
            if (cnt == ack_delay) begin
                resp_ack   = 1'b1;
                resp_rdata = rd_val;
            end else begin
                cnt++;
            end
        end else begin
            cnt  = 0;
            seen = 1'b0;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] reg2,
                         input int dly, input logic [31:0] rdata,
                         input bit has_bus, input bus_t b, input res_t r);
        @(posedge clk);
        #1;
        ex_op = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_addr = addr; ex_reg2 = reg2;
        ack_delay = dly;
        rd_val    = rdata;
        if (has_bus) bus_q.push_back(b);
        res_q.push_back(r);
        live = 1'b1;
        for (int i = 0; i < 200 && live; i++) @(posedge clk);
        if (live) begin
            chk("result_timeout", 32'd1, 32'd0);
            live = 1'b0;
            res_q.delete();
        end
        #1 ex_op = 4'd0;
    endtask

    bus_t nb;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        nb  = '{1'b0, 32'h0, 4'h0, 32'h0};
        rst = 1'b1;
        ex_op = 4'd0; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h5555AAAA;
        ex_addr = 32'h0; ex_reg2 = 32'h0;
        #1;
        chk("rst_stallreq",  32'(stallreq),  32'd0);
        chk("rst_mem_wd",    32'(mem_wd),    32'd0);
        chk("rst_mem_wreg",  32'(mem_wreg),  32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_bus_req",   32'(bus.bus_req), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ALU pass-through, including an out-of-range op code
        issue(4'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 0, 32'h0, 1'b0, nb,
              '{5'd5, 1'b1, 32'h1234, 1'b0, 0});
        issue(4'd9, 5'd3, 1'b1, 32'hDEAD0001, 32'h0, 32'h0, 0, 32'h0, 1'b0, nb,
              '{5'd3, 1'b1, 32'hDEAD0001, 1'b0, 0});
        // LB / LBU at byte lane 1 with a 3-cycle wait
        issue(4'd1, 5'd8, 1'b1, 32'h101, 32'h101, 32'h0, 3, 32'h11F23344, 1'b1,
              '{1'b0, 32'h100, 4'b0100, 32'h0}, '{5'd8, 1'b1, 32'hFFFFFFF2, 1'b0, 5});
        issue(4'd2, 5'd9, 1'b1, 32'h101, 32'h101, 32'h0, 3, 32'h11F23344, 1'b1,
              '{1'b0, 32'h100, 4'b0100, 32'h0}, '{5'd9, 1'b1, 32'h000000F2, 1'b0, 5});
        // SH lower half; wreg must be suppressed
        issue(4'd7, 5'd10, 1'b1, 32'h202, 32'h202, 32'hAAAABEEF, 1, 32'h0, 1'b1,
              '{1'b1, 32'h200, 4'b0011, 32'hBEEFBEEF}, '{5'd10, 1'b0, 32'h202, 1'b0, 3});
        // Zero-wait LW
        issue(4'd5, 5'd11, 1'b1, 32'h100, 32'h100, 32'h0, 0, 32'hCAFEBABE, 1'b1,
              '{1'b0, 32'h100, 4'b1111, 32'h0}, '{5'd11, 1'b1, 32'hCAFEBABE, 1'b0, 2});
        issue(4'd3, 5'd12, 1'b1, 32'h102, 32'h102, 32'h0, 2, 32'h12348001, 1'b1,
              '{1'b0, 32'h100, 4'b0011, 32'h0}, '{5'd12, 1'b1, 32'hFFFF8001, 1'b0, 4});
        issue(4'd4, 5'd13, 1'b1, 32'h100, 32'h100, 32'h0, 0, 32'h80011234, 1'b1,
              '{1'b0, 32'h100, 4'b1100, 32'h0}, '{5'd13, 1'b1, 32'h00008001, 1'b0, 2});
        issue(4'd1, 5'd14, 1'b1, 32'h103, 32'h103, 32'h0, 0, 32'hAABBCC7F, 1'b1,
              '{1'b0, 32'h100, 4'b0001, 32'h0}, '{5'd14, 1'b1, 32'h0000007F, 1'b0, 2});
        issue(4'd6, 5'd15, 1'b1, 32'h103, 32'h103, 32'h12345655, 0, 32'h0, 1'b1,
              '{1'b1, 32'h100, 4'b0001, 32'h55555555}, '{5'd15, 1'b0, 32'h103, 1'b0, 2});
        issue(4'd8, 5'd16, 1'b0, 32'h104, 32'h104, 32'h89ABCDEF, 1, 32'h0, 1'b1,
              '{1'b1, 32'h104, 4'b1111, 32'h89ABCDEF}, '{5'd16, 1'b0, 32'h104, 1'b0, 3});
`ifdef MEM_ALIGN_CHECK_EN
        issue(4'd5, 5'd17, 1'b1, 32'h102, 32'h102, 32'h0, 0, 32'h01234567, 1'b0, nb,
              '{5'd17, 1'b0, 32'h102, 1'b1, 0});
        issue(4'd4, 5'd18, 1'b1, 32'h101, 32'h101, 32'h0, 0, 32'hBEEF0000, 1'b0, nb,
              '{5'd18, 1'b0, 32'h101, 1'b1, 0});
`else
        issue(4'd5, 5'd17, 1'b1, 32'h102, 32'h102, 32'h0, 0, 32'h01234567, 1'b1,
              '{1'b0, 32'h100, 4'b1111, 32'h0}, '{5'd17, 1'b1, 32'h01234567, 1'b0, 2});
        issue(4'd4, 5'd18, 1'b1, 32'h101, 32'h101, 32'h0, 0, 32'hBEEF0000, 1'b1,
              '{1'b0, 32'h100, 4'b1100, 32'h0}, '{5'd18, 1'b1, 32'h0000BEEF, 1'b0, 2});
`endif

        // Reset while BUSY, then a stray ack must be ignored
        @(posedge clk);
        #1;
        ex_op = 4'd5; ex_wd = 5'd20; ex_wreg = 1'b1; ex_addr = 32'h300; ex_wdata = 32'h300;
        ack_delay = 1000;
        bus_q.push_back('{1'b0, 32'h300, 4'b1111, 32'h0});
        repeat (3) @(posedge clk);
        #1;
        chk("busy_bus_req", 32'(bus.bus_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_bus_req",  32'(bus.bus_req),  32'd0);
        chk("midrst_bus_addr", bus.bus_addr,      32'd0);
        chk("midrst_bus_sel",  32'(bus.bus_sel),  32'd0);
        chk("midrst_stallreq", 32'(stallreq),     32'd0);
        chk("midrst_mem_wd",   32'(mem_wd),       32'd0);
        ex_op = 4'd0; ex_wreg = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        man_ack = 1'b1;
        @(posedge clk);
        #1 man_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_stallreq", 32'(stallreq),    32'd0);
        chk("late_ack_bus_req",  32'(bus.bus_req), 32'd0);
        chk("late_ack_mem_wreg", 32'(mem_wreg),    32'd0);
        chk("late_ack_wdata",    mem_wdata,        32'h300);
        issue(4'd0, 5'd21, 1'b1, 32'h77, 32'h0, 32'h0, 0, 32'h0, 1'b0, nb,
              '{5'd21, 1'b1, 32'h77, 1'b0, 0});

        repeat (3) @(posedge clk);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
